// File: rtl/edge_setup.sv
// Triangle edge-setup: three vertices in, winding-normalised edge equations and 2x area out.
// A single shared fixed-point multiplier is time-multiplexed over eight products.
package celery_pkg;
  typedef logic signed [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
    fp32_t c;
    logic  top_left;
  } edge_t;

  // S15.16 multiply: full 64-bit product, shifted back to 16 fraction bits and truncated.
  function automatic fp32_t fp_mul(input fp32_t a, input fp32_t b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return fp32_t'(p >>> 16);
  endfunction
endpackage

module edge_setup
  import celery_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] v0_x,
  input  logic [31:0] v0_y,
  input  logic [31:0] v1_x,
  input  logic [31:0] v1_y,
  input  logic [31:0] v2_x,
  input  logic [31:0] v2_y,
  output logic        out_valid,
  input  logic        out_ready,
  output edge_t       edge0,
  output edge_t       edge1,
  output edge_t       edge2,
  output logic [31:0] area2,
  output logic        cull
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned N_PROD   = 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PROD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;

  fp32_t x0, y0, x1, y1, x2, y2;
  fp32_t prod [N_PROD];
  fp32_t mul_a, mul_b, mul_p;

  fp32_t a0, b0, c0, a1, b1, c1, a2, b2, c2;
  fp32_t raw_area;
  logic  degenerate;
  logic  flip;
  edge_t e0_n, e1_n, e2_n;

  logic accept, mul_step, fin_step, handshake;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid)        state_nx = MUL;
      MUL:  if (idx == IDX_LAST) state_nx = FIN;
      FIN:  state_nx = degenerate ? IDLE : OUT;
      OUT:  if (out_ready)       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    accept    = 1'b0;
    mul_step  = 1'b0;
    fin_step  = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: accept    = in_valid;
      MUL:  mul_step  = 1'b1;
      FIN:  fin_step  = 1'b1;
      OUT:  handshake = out_ready;
      default: ;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Operand select: area cross product first, then the three vertex-pair cross terms
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (idx)
      3'd0: begin mul_a = x1 - x0; mul_b = y2 - y0; end
      3'd1: begin mul_a = x2 - x0; mul_b = y1 - y0; end
      3'd2: begin mul_a = x1;      mul_b = y2;      end
      3'd3: begin mul_a = x2;      mul_b = y1;      end
      3'd4: begin mul_a = x2;      mul_b = y0;      end
      3'd5: begin mul_a = x0;      mul_b = y2;      end
      3'd6: begin mul_a = x0;      mul_b = y1;      end
      3'd7: begin mul_a = x1;      mul_b = y0;      end
      default: ;
    endcase
  end

  assign mul_p = fp_mul(mul_a, mul_b);

  function automatic fp32_t cond_neg(input fp32_t v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Negate on reversed winding, then derive the top-left fill rule from the result
  function automatic edge_t make_edge(input fp32_t a, input fp32_t b, input fp32_t c,
                                      input logic neg);
    edge_t e;
    fp32_t na;
    fp32_t nb;
    na         = cond_neg(a, neg);
    nb         = cond_neg(b, neg);
    e.a        = na;
    e.b        = nb;
    e.c        = cond_neg(c, neg);
    e.top_left = (na > 0) || ((na == 0) && (nb > 0));
    return e;
  endfunction

  assign a0 = y1 - y2;
  assign b0 = x2 - x1;
  assign a1 = y2 - y0;
  assign b1 = x0 - x2;
  assign a2 = y0 - y1;
  assign b2 = x1 - x0;

  assign raw_area   = prod[0] - prod[1];
  assign c0         = prod[2] - prod[3];
  assign c1         = prod[4] - prod[5];
  assign c2         = prod[6] - prod[7];
  assign degenerate = (raw_area == 0);
  assign flip       = (raw_area < 0);

  assign e0_n = make_edge(a0, b0, c0, flip);
  assign e1_n = make_edge(a1, b1, c1, flip);
  assign e2_n = make_edge(a2, b2, c2, flip);

  // Vertex capture, product accumulation and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0        <= '0;
      y0        <= '0;
      x1        <= '0;
      y1        <= '0;
      x2        <= '0;
      y2        <= '0;
      idx       <= '0;
      for (int i = 0; i < int'(N_PROD); i++) prod[i] <= '0;
      out_valid <= 1'b0;
      cull      <= 1'b0;
      edge0     <= '0;
      edge1     <= '0;
      edge2     <= '0;
      area2     <= '0;
    end else begin
      cull <= 1'b0;
      if (accept) begin
        x0  <= v0_x;
        y0  <= v0_y;
        x1  <= v1_x;
        y1  <= v1_y;
        x2  <= v2_x;
        y2  <= v2_y;
        idx <= '0;
      end
      if (mul_step) begin
        prod[idx] <= mul_p;
        idx       <= idx + IDX_W'(1);
      end
      if (fin_step) begin
        if (degenerate) begin
          cull <= 1'b1;
        end else begin
          edge0     <= e0_n;
          edge1     <= e1_n;
          edge2     <= e2_n;
          area2     <= cond_neg(raw_area, flip);
          out_valid <= 1'b1;
        end
      end
      if (handshake) out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/edge_setup.md
# edge_setup

Triangle edge-setup engine: accepts three screen-space vertices and produces the three `edge_t` coefficient sets (A, B, C, top_left) consumed by the per-pixel edge evaluators, plus twice the signed triangle area. It normalises winding so that interior pixels give E ≥ 0, and culls degenerate triangles. It sits between the vertex/transform stage and the rasteriser. It uses one shared `fp_mul` instance, time-multiplexed over eight products.

## Interface
- No parameters. All arithmetic uses `celery_pkg`: `fp32_t` is 32-bit signed S15.16, `fp_mul` is the package fixed-point multiply, and `edge_t` is {a, b, c, top_left}.
- `clk`  in  1  clock; the only clock domain.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  vertex triple valid.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `v0_x, v0_y, v1_x, v1_y, v2_x, v2_y`  in  32 each (`fp32_t`)  vertex coordinates, y-down screen space.
- `out_valid`  out  1  edge set valid.
- `out_ready`  in  1  downstream accepts.
- `edge0, edge1, edge2`  out  `edge_t`  edge0 is edge v1→v2, edge1 is edge v2→v0, edge2 is edge v0→v1.
- `area2`  out  32 (`fp32_t`)  twice the triangle area after normalisation; always > 0 when `out_valid` is high.
- `cull`  out  1  one-cycle pulse marking a degenerate triangle that was dropped.

## Operation
- **States:** IDLE → MUL (8 cycles, index 0..7) → FIN → OUT → IDLE. FIN goes directly to IDLE when the triangle is culled.
- **IDLE:** on in_valid && in_ready, register all vertices and move to MUL.
  - Edge Ai = y_start − y_end.
  - Edge Bi = x_end − x_start.
- **MUL:** one `fp_mul` product is registered per cycle, in this order:
  - (x1−x0)·(y2−y0) and (x2−x0)·(y1−y0);
  - x1·y2 and x2·y1;
  - x2·y0 and x0·y2;
  - x0·y1 and x1·y0.
- **Results of the MUL products:**
  - Raw area = P0 − P1.
  - C0 = P2 − P3, C1 = P4 − P5, C2 = P6 − P7.
- **FIN, degenerate case:** if raw area == 0, pulse `cull` for 1 cycle, leave `out_valid` low, and go to IDLE.
- **FIN, negative winding:** if raw area < 0, negate A, B and C of all three edges and negate the area.
- **FIN, top_left:** compute from the normalised coefficients as top_left = (A > 0) || (A == 0 && B > 0).
- **FIN, outputs:** register all outputs and set `out_valid`.
- **OUT:** hold every output stable while out_ready is low. On out_valid && out_ready, clear `out_valid` and go to IDLE.
- **Width rules:** all add, subtract and negate operations are 32-bit two's-complement and wrap, with no saturation. Products are truncated as `fp_mul` defines them. Keeping coordinates within range is the sender's responsibility.
- **in_valid while not IDLE:** ignored; the sender must hold it.
- **Reset, any state, including mid-MUL:**
  - state goes to IDLE;
  - `out_valid`, `cull`, `edge*` and `area2` are all zero;
  - `in_ready` reads 1 once state is IDLE, including while rst_n is held low.

## Timing
- The accepting clock edge is T0.
- Products are captured on edges T1..T8.
- `out_valid` (or the `cull` pulse) appears after edge T9, so latency is 9 cycles.
- `in_ready` is low from T0 until the cycle after OUT is accepted, or the cycle after the cull pulse.
- Best-case throughput is 1 triangle per 11 cycles when out_ready is held high.
- `out_valid` never drops without a handshake, except on reset.
- All outputs are registered; `in_ready` is decoded directly from the state register.

## Test plan
- **CCW right triangle:** v0=(0,0), v1=(4,0), v2=(0,4) → after 9 cycles:
  - area2 = 0x0010_0000;
  - edge0 = {0xFFFC_0000, 0xFFFC_0000, 0x0010_0000, 0};
  - edge1 = {0x0004_0000, 0, 0, 1};
  - edge2 = {0, 0x0004_0000, 0, 1}.
- **Reversed winding:** v1=(0,4), v2=(4,0) → area2 = 0x0010_0000;
  - edge0 = {−4, −4, 16, 0};
  - edge1 = {0, 4, 0, 1};
  - edge2 = {4, 0, 0, 1} (values in S15.16).
- **Degenerate:** v0=(0,0), v1=(1,1), v2=(2,2) → `cull` is high for exactly 1 cycle at T9, `out_valid` never rises, and `in_ready` returns high.
- **Backpressure:** hold out_ready low for 5 cycles after out_valid rises → all outputs stable and in_ready low throughout; accept on cycle 6, and in_ready is high the next cycle. A new in_valid offered during the stall is not accepted.
- **Reset mid-MUL:** drop rst_n 4 cycles after acceptance → all outputs are zero immediately. After release, the triangle from the first scenario completes with the same results.
- **Self-consistency:** for random in-range triangles, check area2 > 0 and Ei(vi) == area2 within fp_mul rounding. Scoreboard against the coefficient formulas above.
